bcd2b_seq_ip: RTL and testbench



---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_digit_adj.sv | 15 +
 rtl/bcd2b_seq_ip.sv | 121 ++++++++++++
 tb/tb_bcd2b_seq_ip.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  // Reverse double-dabble correction: digits at or above BCD_THR lose BCD_ADJ after each right shift.
  localparam logic [3:0] BCD_ADJ = 4'd3;
  localparam logic [3:0] BCD_THR = 4'd8;

  // Number of bits needed to hold values 0..v-1 (minimum 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step: d >= 8 ? d - 3 : d (mod 16).
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  // Combinational digit correction.
  always_comb begin
    d_o = d_i;
    if (d_i >= BCD_THR) d_o = d_i - BCD_ADJ;
  end

endmodule

// File: rtl/bcd2b_seq_ip.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble, one step per clock).
module bcd2b_seq_ip
  import bcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DIGIT*4-1:0] BCD_code,
  output logic               busy,
  output logic               out_valid,
  output logic [WIDTH-1:0]   Binary_code,
  output logic               bcd_err,
  output logic               ovf
);

  localparam int unsigned BW = DIGIT * 4;
  localparam int unsigned SW = BW + WIDTH;
  localparam int unsigned CW = clog2(WIDTH + 1);

  if (WIDTH < 4 || DIGIT < 1) begin : g_param_check
    $error("bcd2b_seq_ip: WIDTH must be >= 4 and DIGIT >= 1");
  end

  state_e          state_q, state_d;
  logic [SW-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            out_valid_q, out_valid_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic            bcd_err_q, bcd_err_d;
  logic            ovf_q, ovf_d;

  logic [SW-1:0]   shifted;
  logic [SW-1:0]   adjusted;
  logic            in_err;

  assign shifted = sreg_q >> 1;
  assign adjusted[WIDTH-1:0] = shifted[WIDTH-1:0];

  for (genvar g = 0; g < DIGIT; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (shifted[WIDTH + 4*g +: 4]),
      .d_o (adjusted[WIDTH + 4*g +: 4])
    );
  end

  // Flag any input digit outside 0..9.
  always_comb begin
    in_err = 1'b0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      if (BCD_code[4*i +: 4] > 4'd9) in_err = 1'b1;
    end
  end

  // Next-state logic; result outputs are produced on the final iteration edge, so no DONE state exists.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    bin_d       = '0;
    bcd_err_d   = 1'b0;
    ovf_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d  = {BCD_code, {WIDTH{1'b0}}};
          cnt_d   = '0;
          err_d   = in_err;
          state_d = CONV;
        end
      end
      CONV: begin
        sreg_d = adjusted;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          bcd_err_d   = err_q;
          ovf_d       = (adjusted[SW-1:WIDTH] != '0) & ~err_q;
          bin_d       = err_q ? '0 : adjusted[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      bin_q       <= '0;
      bcd_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      bin_q       <= bin_d;
      bcd_err_q   <= bcd_err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy        = (state_q == CONV);
  assign out_valid   = out_valid_q;
  assign Binary_code = bin_q;
  assign bcd_err     = bcd_err_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_bcd2b_seq_ip.sv
// Self-checking bench for bcd2b_seq_ip with WIDTH=8, DIGIT=3.
module tb_bcd2b_seq_ip;

  localparam int WIDTH = 8;
  localparam int DIGIT = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic [DIGIT*4-1:0] BCD_code = '0;
  logic               busy;
  logic               out_valid;
  logic [WIDTH-1:0]   Binary_code;
  logic               bcd_err;
  logic               ovf;

  int total = 0;
  int bad   = 0;

  bcd2b_seq_ip #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .BCD_code    (BCD_code),
    .busy        (busy),
    .out_valid   (out_valid),
    .Binary_code (Binary_code),
    .bcd_err     (bcd_err),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  typedef struct {
    logic [11:0] bcd;
    logic [7:0]  bin;
    logic        ovf;
    logic        err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference: decimal value from the digits, then plain arithmetic.
  function automatic void model(input logic [11:0] b, output logic [7:0] bin,
                                output logic o, output logic e);
    int unsigned v, p, d;
    logic [11:0] t;
    v = 0; p = 1; e = 1'b0; t = b;
    for (int i = 0; i < DIGIT; i++) begin
      d = int'(t[3:0]);
      if (d > 9) e = 1'b1;
      v += d * p;
      p *= 10;
      t = t >> 4;
    end
    bin = e ? 8'h00 : 8'(v % 256);
    o   = !e && (v >= 256);
  endfunction

  // Launch one conversion and check busy window, exact latency, result and clearing.
  task automatic convert(input string name, input logic [11:0] bcd,
                         input logic [7:0] eb, input logic eo, input logic ee);
    logic busy_ok;
    @(negedge clk);
    in_valid = 1'b1;
    BCD_code = bcd;
    @(negedge clk);
    in_valid = 1'b0;
    busy_ok  = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (i > 0) @(negedge clk);
      if (busy !== 1'b1 || out_valid !== 1'b0) busy_ok = 1'b0;
    end
    chk({name, "_busy_window"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    chk({name, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_busy_low"}, 32'(busy), 32'd0);
    chk({name, "_bin"}, 32'(Binary_code), 32'(eb));
    chk({name, "_ovf"}, 32'(ovf), 32'(eo));
    chk({name, "_err"}, 32'(bcd_err), 32'(ee));
    @(negedge clk);
    chk({name, "_valid_clear"}, 32'(out_valid), 32'd0);
    chk({name, "_bin_clear"}, 32'(Binary_code), 32'd0);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{bcd: 12'h255, bin: 8'hFF, ovf: 1'b0, err: 1'b0};
    tbl[1] = '{bcd: 12'h099, bin: 8'h63, ovf: 1'b0, err: 1'b0};
    tbl[2] = '{bcd: 12'h000, bin: 8'h00, ovf: 1'b0, err: 1'b0};
    tbl[3] = '{bcd: 12'h256, bin: 8'h00, ovf: 1'b1, err: 1'b0};
    tbl[4] = '{bcd: 12'h999, bin: 8'hE7, ovf: 1'b1, err: 1'b0};
    tbl[5] = '{bcd: 12'h1A3, bin: 8'h00, ovf: 1'b0, err: 1'b1};

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bin", 32'(Binary_code), 32'd0);
    chk("rst_flags", 32'({bcd_err, ovf}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    foreach (tbl[k]) begin
      convert($sformatf("tbl%0d", k), tbl[k].bcd, tbl[k].bin, tbl[k].ovf, tbl[k].err);
    end

    // Busy drop and back-to-back acceptance
    begin
      int pulses;
      pulses = 0;
      @(negedge clk);
      in_valid = 1'b1;
      BCD_code = 12'h042;
      for (int j = 0; j <= 25; j++) begin
        @(negedge clk);
        if (out_valid === 1'b1) pulses++;
        chk($sformatf("thr_valid_j%0d", j), 32'(out_valid), 32'((j == 8) || (j == 17)));
        if (j == 8)  chk("thr_bin_first", 32'(Binary_code), 32'h2A);
        if (j == 17) chk("thr_bin_second", 32'(Binary_code), 32'h80);
        if (j == 2)  chk("thr_busy_at_drop", 32'(busy), 32'd1);
        if (j == 8)  chk("thr_idle_at_result", 32'(busy), 32'd0);
        in_valid = (j == 2) || (j == 8);
        BCD_code = (j == 2) ? 12'h007 : 12'h128;
      end
      in_valid = 1'b0;
      chk("thr_pulse_count", 32'(pulses), 32'd2);
    end

    // Reset during conversion
    begin
      int seen;
      seen = 0;
      @(negedge clk);
      in_valid = 1'b1;
      BCD_code = 12'h200;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_outs", 32'({out_valid, Binary_code, bcd_err, ovf}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < 12; j++) begin
        @(negedge clk);
        if (out_valid === 1'b1) seen++;
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
      convert("after_abort", 12'h010, 8'h0A, 1'b0, 1'b0);
    end

    // Randomized against the arithmetic model
    for (int r = 0; r < 40; r++) begin
      logic [11:0] b;
      logic [7:0]  eb;
      logic        eo, ee;
      if (r % 3 == 2) begin
        b = 12'($urandom);
      end else begin
        b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end
      model(b, eb, eo, ee);
      convert($sformatf("rnd%0d_%03h", r, b), b, eb, eo, ee);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
